ccd_line_framer: RTL and testbench

- Downstream stage of the AD9235 ADC driver.
- Consumes the raw pixel_data/pixel_valid stream and uses the CCD line-start pulse to frame each line.
- Discards dummy pixels, averages optically-black (dark) pixels, subtracts the dark level from active pixels with a clamp at zero, and buffers the result.
- Output is a ready/valid stream with start/end-of-line flags for the storage/transfer logic.

---
 rtl/ccd_pkg.sv | 36 +++
 rtl/ccd_sync_fifo.sv | 48 ++++
 rtl/ccd_line_framer.sv | 159 +++++++++++++++
 tb/tb_ccd_line_framer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and sizing helpers for the CCD line framer.
// FRAMER_TEST_PATTERN_EN (see ccd_line_framer) needs nothing from here.
package ccd_pkg;

  localparam int DEF_DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    DARK,
    ACTIVE,
    DONE
  } state_t;

  typedef struct packed {
    logic                  sol;
    logic                  eol;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic int cnt_w(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  function automatic int acc_w(int dw, int dark);
    return dw + $clog2(dark);
  endfunction

  localparam int DEF_CNT_W = cnt_w(16, 16, 2048);
  localparam int DEF_ACC_W = acc_w(DEF_DATA_W, 16);

endpackage

// File: rtl/ccd_sync_fifo.sv
// Single-clock show-ahead FIFO; rd_data is the head entry while !empty.
// Write while full succeeds only when a read frees a slot that cycle.
module ccd_sync_fifo
  import ccd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ccd_line_framer.sv
// CCD line framer: skip dummies, average dark pixels, dark-correct actives.
// `define FRAMER_TEST_PATTERN_EN adds test_pattern (column-index output).
module ccd_line_framer
  import ccd_pkg::*;
#(
  parameter int DATA_W     = ccd_pkg::DEF_DATA_W,
  parameter int DUMMY_PIX  = 16,
  parameter int DARK_PIX   = 16,
  parameter int ACTIVE_PIX = 2048,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [DATA_W-1:0] pixel_data,
  input  logic              pixel_valid,
`ifdef FRAMER_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sol,
  output logic              out_eol,
  output logic [DATA_W-1:0] dark_level,
  output logic [15:0]       line_count,
  output logic              overflow,
  output logic              short_line
);

  localparam int CNT_W = cnt_w(DUMMY_PIX, DARK_PIX, ACTIVE_PIX);
  localparam int ACC_W = acc_w(DATA_W, DARK_PIX);
  localparam int SH    = $clog2(DARK_PIX);
  localparam int EW    = DATA_W + 2;

  state_t            state_q, state_d, cur_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cur_cnt;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_base;
  logic [DATA_W-1:0] dark_q;
  logic [15:0]       line_q;
  logic              short_q, ovf_q;
  logic              dark_ld, emit, eol_hit, short_hit;
  logic              tp;
  logic [DATA_W-1:0] corr, px_out;
  logic              s_valid;
  logic [EW-1:0]     s_entry, rd_entry;
  logic              fifo_full, fifo_empty, rd_en, wr_drop;

`ifdef FRAMER_TEST_PATTERN_EN
  assign tp = test_pattern;
`else
  assign tp = 1'b0;
`endif

  // line_start restarts the line before this cycle's pixel is classified
  always_comb begin
    cur_state = line_start ? SKIP : state_q;
    cur_cnt   = line_start ? '0 : cnt_q;
    acc_base  = line_start ? '0 : acc_q;
    state_d   = cur_state;
    cnt_d     = cur_cnt;
    acc_d     = acc_base;
    dark_ld   = 1'b0;
    emit      = 1'b0;
    eol_hit   = 1'b0;
    short_hit = line_start &&
                (state_q inside {SKIP, DARK, ACTIVE});
    if (pixel_valid) begin
      unique case (cur_state)
        SKIP: begin
          if (cur_cnt == CNT_W'(DUMMY_PIX - 1)) begin
            state_d = DARK;
            cnt_d   = '0;
          end else begin
            cnt_d = cur_cnt + 1'b1;
          end
        end
        DARK: begin
          acc_d = acc_base + ACC_W'(pixel_data);
          if (cur_cnt == CNT_W'(DARK_PIX - 1)) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            dark_ld = 1'b1;
          end else begin
            cnt_d = cur_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          emit = 1'b1;
          if (cur_cnt == CNT_W'(ACTIVE_PIX - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            eol_hit = 1'b1;
          end else begin
            cnt_d = cur_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign corr   = (pixel_data >= dark_q) ?
                  pixel_data - dark_q : '0;
  assign px_out = tp ? DATA_W'(cur_cnt) : corr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dark_q  <= '0;
      line_q  <= '0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
      s_valid <= 1'b0;
      s_entry <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (dark_ld)   dark_q  <= DATA_W'(acc_d >> SH);
      if (eol_hit)   line_q  <= line_q + 16'd1;
      if (short_hit) short_q <= 1'b1;
      if (wr_drop)   ovf_q   <= 1'b1;
      s_valid <= emit;
      if (emit)
        s_entry <= {cur_cnt == '0, eol_hit, px_out};
    end
  end

  // when full the FIFO is non-empty, so a read is exactly out_ready
  assign rd_en   = out_ready & ~fifo_empty;
  assign wr_drop = s_valid & fifo_full & ~out_ready;

  ccd_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_valid),
    .wr_data (s_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign out_sol    = out_valid & rd_entry[EW-1];
  assign out_eol    = out_valid & rd_entry[EW-2];
  assign out_data   = out_valid ? rd_entry[DATA_W-1:0] : '0;
  assign dark_level = dark_q;
  assign line_count = line_q;
  assign overflow   = ovf_q;
  assign short_line = short_q;

endmodule

// File: tb/tb_ccd_line_framer.sv
// Directed bench for ccd_line_framer with a small line geometry.
// Hand-computed expectations; accepted beats are logged at negedge.
module tb_ccd_line_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [11:0] pixel_data;
  logic        pixel_valid;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sol;
  logic        out_eol;
  logic [11:0] dark_level;
  logic [15:0] line_count;
  logic        overflow;
  logic        short_line;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] cap_q[$];
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  ccd_line_framer #(
    .DATA_W     (12),
    .DUMMY_PIX  (4),
    .DARK_PIX   (4),
    .ACTIVE_PIX (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_start  (line_start),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
`ifdef FRAMER_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sol     (out_sol),
    .out_eol     (out_eol),
    .dark_level  (dark_level),
    .line_count  (line_count),
    .overflow    (overflow),
    .short_line  (short_line)
  );

  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      cap_q.push_back({out_sol, out_eol, out_data});

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int d);
    pixel_valid = 1'b1;
    pixel_data  = 12'(d);
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic ls();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic body(input int d0, input int d1,
                      input int d2, input int d3);
    repeat (4) px(4095);
    px(d0);
    px(d1);
    px(d2);
    px(d3);
  endtask

  task automatic ex(input bit sol, input bit eol,
                    input int d);
    exp_q.push_back({sol, eol, 12'(d)});
  endtask

  task automatic cmp_caps(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check(tag, 32'(cap_q[i]), 32'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_sol"}, out_sol, 0);
    check({tag, "_eol"}, out_eol, 0);
    check({tag, "_dark"}, dark_level, 0);
    check({tag, "_lines"}, line_count, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_short"}, short_line, 0);
  endtask

  initial begin
    rst         = 1'b1;
    line_start  = 1'b0;
    pixel_data  = '0;
    pixel_valid = 1'b0;
    out_ready   = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // basic line: dark avg 100, actives 200..207
    ls();
    body(100, 102, 98, 100);
    check("basic_dark", dark_level, 100);
    px(200);
    check("lat_1cyc", out_valid, 0);
    px(201);
    check("lat_2cyc", out_valid, 1);
    for (int i = 2; i < 8; i++) px(200 + i);
    repeat (4) tick();
    for (int i = 0; i < 8; i++) ex(i == 0, i == 7, 100 + i);
    cmp_caps("basic");
    check("basic_lines", line_count, 1);

    // collision + clamp + pixels ignored in DONE
    line_start  = 1'b1;
    pixel_valid = 1'b1;
    pixel_data  = 12'd4095;
    tick();
    line_start  = 1'b0;
    pixel_valid = 1'b0;
    repeat (3) px(4095);
    repeat (4) px(500);
    check("clamp_dark", dark_level, 500);
    px(400);
    px(600);
    for (int i = 0; i < 6; i++) px(500 + i);
    repeat (3) px(1000);
    repeat (4) tick();
    ex(1, 0, 0);
    ex(0, 0, 100);
    for (int i = 0; i < 6; i++) ex(0, i == 5, i);
    cmp_caps("clamp");
    check("clamp_lines", line_count, 2);
    check("done_idle", out_valid, 0);

    // backpressure: 8 actives into a 4-deep FIFO
    out_ready = 1'b0;
    ls();
    body(100, 100, 100, 100);
    for (int i = 0; i < 8; i++) px(300 + i);
    repeat (3) tick();
    check("bp_ovf", overflow, 1);
    check("bp_valid", out_valid, 1);
    check("bp_sol", out_sol, 1);
    check("bp_lines", line_count, 3);
    repeat (2) tick();
    check("bp_hold", out_data, 200);
    out_ready = 1'b1;
    repeat (6) tick();
    ex(1, 0, 200);
    for (int i = 1; i < 4; i++) ex(0, 0, 200 + i);
    cmp_caps("bp");
    check("bp_drained", out_valid, 0);

    // short line after 3 actives, then a full line
    ls();
    body(200, 200, 200, 200);
    px(300);
    px(301);
    px(302);
    ls();
    check("short_flag", short_line, 1);
    check("short_lines", line_count, 3);
    body(40, 44, 48, 52);
    check("short_dark", dark_level, 46);
    for (int i = 0; i < 8; i++) px(100 + i);
    repeat (4) tick();
    ex(1, 0, 100);
    ex(0, 0, 101);
    ex(0, 0, 102);
    for (int i = 0; i < 8; i++) ex(i == 0, i == 7, 54 + i);
    cmp_caps("short");
    check("short_lines2", line_count, 4);

    // reset in the middle of ACTIVE with data buffered
    out_ready = 1'b0;
    ls();
    body(0, 0, 0, 0);
    px(50);
    px(51);
    repeat (3) tick();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("mid_rst");
    out_ready = 1'b1;
    repeat (10) px(300);
    repeat (4) tick();
    cmp_caps("idle_ignore");
    check("idle_valid", out_valid, 0);
    ls();
    body(10, 10, 10, 10);
    for (int i = 0; i < 8; i++) px(20 + i);
    repeat (4) tick();
    for (int i = 0; i < 8; i++) ex(i == 0, i == 7, 10 + i);
    cmp_caps("post_rst");
    check("post_rst_lines", line_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
